// File: rtl/count_display_pkg.sv
// Shared constants for the two-digit count display: segment patterns,
// anode codes and the digit-slot state encoding.
package count_display_pkg;

  typedef enum logic {
    DIG0 = 1'b0,
    DIG1 = 1'b1
  } dig_state_t;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] AN_ONES = 4'b1110;
  localparam logic [3:0] AN_TENS = 4'b1101;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  localparam int unsigned RCNT_W = 16;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low seven-segment pattern; codes above 9 blank.
module seg7_decode
  import count_display_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    unique case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/count_display.sv
// Captures a 4-bit count and multiplexes it as two decimal digits onto a
// common-anode seven-segment display, flagging 15->0 wraps of the count.
module count_display
  import count_display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter bit          LZ_BLANK    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] a,
  input  logic       load,
  input  logic       freeze,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic [3:0] value,
  output logic       wrap
);

  dig_state_t        state, state_nxt;
  logic [RCNT_W-1:0] rcnt;
  logic              rterm;
  logic              capture;
  logic [3:0]        ones;
  logic              tens;
  logic [3:0]        digit_sel;
  logic [6:0]        seg_dec;
  logic [6:0]        seg_nxt;
  logic [3:0]        an_nxt;

  assign capture = load && !freeze;
  assign rterm   = (rcnt == RCNT_W'(REFRESH_DIV - 1));

  // Count capture and wrap detection
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
      wrap  <= 1'b0;
    end else begin
      wrap <= capture && (value == 4'd15) && (a == 4'd0);
      if (capture) value <= a;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)        rcnt <= '0;
    else if (rterm) rcnt <= '0;
    else            rcnt <= rcnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= DIG0;
    else     state <= state_nxt;
  end

  assign tens      = (value >= 4'd10);
  assign ones      = tens ? (value - 4'd10) : value;
  assign digit_sel = (state == DIG0) ? ones : {3'b000, tens};

  seg7_decode u_dec (
    .digit (digit_sel),
    .seg   (seg_dec)
  );

  // Slot toggles only on the refresh terminal; display drive follows current slot
  always_comb begin
    state_nxt = state;
    seg_nxt   = SEG_BLANK;
    an_nxt    = AN_OFF;
    if (rterm) state_nxt = (state == DIG0) ? DIG1 : DIG0;
    if (state == DIG0) begin
      an_nxt  = AN_ONES;
      seg_nxt = seg_dec;
    end else if (tens || !LZ_BLANK) begin
      an_nxt  = AN_TENS;
      seg_nxt = seg_dec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg <= SEG_BLANK;
      an  <= AN_OFF;
    end else begin
      seg <= seg_nxt;
      an  <= an_nxt;
    end
  end

endmodule

// File: tb/tb_count_display.sv
// Self-checking bench for count_display: directed scenarios then random traffic,
// compared each cycle against an arithmetic reference model.
module tb_count_display;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst, load, freeze;
  logic [3:0] a;
  logic [6:0] seg_b, seg_n;
  logic [3:0] an_b, an_n, value_b, value_n;
  logic       wrap_b, wrap_n;

  int vectors = 0;
  int fails   = 0;

  // reference model state
  int         k;
  logic [3:0] m_value;
  logic       m_wrap;
  logic [6:0] m_seg_b, m_seg_n;
  logic [3:0] m_an_b, m_an_n;

  logic [6:0] pat [10];

  always #5 clk = ~clk;

  count_display #(.REFRESH_DIV(DIV), .LZ_BLANK(1'b1)) dut (
    .clk(clk), .rst(rst), .a(a), .load(load), .freeze(freeze),
    .seg(seg_b), .an(an_b), .value(value_b), .wrap(wrap_b)
  );

  count_display #(.REFRESH_DIV(DIV), .LZ_BLANK(1'b0)) dut_nlz (
    .clk(clk), .rst(rst), .a(a), .load(load), .freeze(freeze),
    .seg(seg_n), .an(an_n), .value(value_n), .wrap(wrap_n)
  );

  function automatic logic [10:0] disp(input bit dig1, input logic [3:0] v, input bit lz);
    int o, t;
    o = int'(v) % 10;
    t = (v >= 4'd10) ? 1 : 0;
    if (!dig1)          return {4'b1110, pat[o]};
    if (t == 1 || !lz)  return {4'b1101, pat[t]};
    return {4'b1111, 7'b1111111};
  endfunction

  task automatic step(input bit r, input bit l, input bit f, input logic [3:0] aa);
    logic [10:0] db, dn;
    bit dig1;
    rst = r; load = l; freeze = f; a = aa;
    @(posedge clk);
    if (r) begin
      k = 0; m_value = 4'd0; m_wrap = 1'b0;
      m_seg_b = 7'h7F; m_an_b = 4'hF; m_seg_n = 7'h7F; m_an_n = 4'hF;
    end else begin
      dig1 = ((k / DIV) % 2) == 1;
      db = disp(dig1, m_value, 1'b1);
      dn = disp(dig1, m_value, 1'b0);
      {m_an_b, m_seg_b} = db;
      {m_an_n, m_seg_n} = dn;
      m_wrap = l && !f && (m_value == 4'd15) && (aa == 4'd0);
      if (l && !f) m_value = aa;
      k++;
    end
    #1;
    vectors++;
    assert (value_b === m_value) else begin
      fails++; $error("FAIL value k=%0d: got %0d expected %0d", k, value_b, m_value);
    end
    vectors++;
    assert (wrap_b === m_wrap) else begin
      fails++; $error("FAIL wrap k=%0d: got %b expected %b", k, wrap_b, m_wrap);
    end
    vectors++;
    assert (seg_b === m_seg_b) else begin
      fails++; $error("FAIL seg k=%0d: got %b expected %b", k, seg_b, m_seg_b);
    end
    vectors++;
    assert (an_b === m_an_b) else begin
      fails++; $error("FAIL an k=%0d: got %b expected %b", k, an_b, m_an_b);
    end
    vectors++;
    assert (seg_n === m_seg_n) else begin
      fails++; $error("FAIL seg_nlz k=%0d: got %b expected %b", k, seg_n, m_seg_n);
    end
    vectors++;
    assert (an_n === m_an_n) else begin
      fails++; $error("FAIL an_nlz k=%0d: got %b expected %b", k, an_n, m_an_n);
    end
    vectors++;
    assert (wrap_n === m_wrap) else begin
      fails++; $error("FAIL wrap_nlz k=%0d: got %b expected %b", k, wrap_n, m_wrap);
    end
  endtask

  initial begin
    pat[0] = 7'b1000000; pat[1] = 7'b1111001; pat[2] = 7'b0100100;
    pat[3] = 7'b0110000; pat[4] = 7'b0011001; pat[5] = 7'b0010010;
    pat[6] = 7'b0000010; pat[7] = 7'b1111000; pat[8] = 7'b0000000;
    pat[9] = 7'b0010000;
    k = 0; m_value = '0; m_wrap = 1'b0;
    m_seg_b = 7'h7F; m_an_b = 4'hF; m_seg_n = 7'h7F; m_an_n = 4'hF;
    rst = 1'b1; load = 1'b0; freeze = 1'b0; a = 4'd0;

    // reset, then idle through several slots (blanked tens on LZ instance)
    repeat (3) step(1, 0, 0, 4'd0);
    repeat (12) step(0, 0, 0, 4'd0);

    // capture 13: ones shows 3, tens shows 1
    step(0, 1, 0, 4'd13);
    repeat (10) step(0, 0, 0, 4'd9);

    // 15 -> 0 wrap, then recapture of 0 must not pulse
    step(0, 1, 0, 4'd15);
    step(0, 0, 0, 4'd0);
    step(0, 1, 0, 4'd0);
    step(0, 0, 0, 4'd0);
    step(0, 1, 0, 4'd0);
    step(0, 0, 0, 4'd0);

    // freeze overrides load, including a would-be wrap
    step(0, 1, 0, 4'd15);
    step(0, 1, 1, 4'd7);
    step(0, 1, 1, 4'd0);
    step(0, 0, 0, 4'd7);
    step(0, 1, 0, 4'd7);
    step(0, 0, 0, 4'd7);

    // value 5: tens blanked vs shown as 0
    step(0, 1, 0, 4'd5);
    repeat (10) step(0, 0, 0, 4'd5);

    // capture inside a DIG1 slot leaves slot timing alone
    while (((k / DIV) % 2) != 1 || (k % DIV) != 1) step(0, 0, 0, 4'd0);
    step(0, 1, 0, 4'd11);
    repeat (6) step(0, 0, 0, 4'd0);

    // reset at rcnt=2 of a DIG1 slot, then full DIG0 slot after release
    while (((k / DIV) % 2) != 1 || (k % DIV) != 2) step(0, 0, 0, 4'd0);
    step(1, 1, 0, 4'd8);
    step(1, 0, 1, 4'd8);
    repeat (10) step(0, 0, 0, 4'd0);

    // random traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 5) == 0),
           4'($urandom_range(0, 15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/count_display.md
COUNT_DISPLAY -- requirements
Module: count_display

Interface
REQ-001 Parameter REFRESH_DIV, default 50000, sets the clock cycles per digit slot; legal range 2..65535.
REQ-002 Parameter LZ_BLANK, default 1; when 1, the tens digit is blanked when the displayed value is below 10.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  system clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 a  input  4  count value from the upstream 4-bit counter.
REQ-007 load  input  1  capture strobe; samples a.
REQ-008 freeze  input  1  holds the displayed value; overrides load.
REQ-009 seg  output  7  active-low segments, bit order {g,f,e,d,c,b,a}.
REQ-010 an  output  4  active-low digit anodes; an[0] is ones, an[1] is tens, an[3:2] are always 1.
REQ-011 value  output  4  currently latched display value.
REQ-012 wrap  output  1  one-cycle pulse on a detected 15->0 capture.

Function
REQ-013 Capture: on a cycle with load=1 and freeze=0, value SHALL become a on the next edge; otherwise value holds.
REQ-014 Wrap: wrap SHALL be 1 for exactly the cycle after a capture in which the old value was 15 and a was 0; otherwise wrap is 0.
REQ-015 A capture of an unchanged value SHALL NOT pulse wrap.
REQ-016 The refresh counter SHALL count 0..REFRESH_DIV-1 and then wrap to 0; the terminal cycle is rcnt==REFRESH_DIV-1.
REQ-017 FSM states are DIG0 (ones) and DIG1 (tens); the FSM toggles DIG0<->DIG1 only on the refresh terminal cycle.
REQ-018 Digit arithmetic: ones = value mod 10, tens = 1 when value>=10 and 0 otherwise; no other values are legal.
REQ-019 seg and an SHALL be registered, reflecting state and value one cycle after they change (one-cycle latency).
REQ-020 In DIG0: an=4'b1110 and seg is the pattern for ones.
REQ-021 In DIG1 with tens=1, or with LZ_BLANK=0: an=4'b1101 and seg is the pattern for tens.
REQ-022 In DIG1 with tens=0 and LZ_BLANK=1: an=4'b1111 and seg=7'b1111111 (blanked).
REQ-023 Segment patterns (active low):
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
- 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
REQ-024 A capture during a DIG1 slot SHALL NOT reset rcnt or the FSM; the new digits appear at the next registered update.
REQ-025 No output SHALL drive two anodes low in the same cycle.

Reset
REQ-026 While rst=1: value=0, wrap=0, rcnt=0, state=DIG0, seg=7'b1111111, an=4'b1111.
REQ-027 rst SHALL take priority over load and freeze.
REQ-028 The first cycle after rst deasserts SHALL present an=4'b1110 and seg=1000000.
REQ-029 Reset asserted mid-slot SHALL restart the slot timing from rcnt=0 in DIG0.

Structure
REQ-030 A shared package count_display_pkg SHALL hold:
- the segment pattern constants (0-9, blank);
- the anode codes;
- the DIG0/DIG1 state encoding.
REQ-031 The combinational digit-to-segment lookup SHALL be one sub-module, seg7_decode (4-bit in, 7-bit out; inputs above 9 give blank).
REQ-032 All other logic (capture, wrap, refresh, FSM, output registers) SHALL reside in count_display.

Verification (REFRESH_DIV=4 unless stated)
REQ-033 Reset then idle -> an=1110, seg=1000000; then after 4 cycles an=1111 (tens blanked); then an=1110 again 4 cycles later.
REQ-034 a=13, load pulse -> value=13; DIG0 shows seg=0110000 (3); DIG1 shows an=1101, seg=1111001 (1).
REQ-035 value=15, then a=0 with load -> wrap=1 for exactly one cycle and value=0; recapture of 0 -> wrap stays 0.
REQ-036 freeze=1 with load=1 and a=7 -> value unchanged, no wrap; after freeze is released and load is pulsed -> value=7.
REQ-037 LZ_BLANK=0, value=5 -> DIG1 shows an=1101, seg=1000000 (0).
REQ-038 Assert rst at rcnt=2 in DIG1 -> outputs all-off during reset; after release, DIG0 is held for a full 4 cycles.
